// File: rtl/seg7_pkg.sv
// seg7_pkg: definitions shared by the seven-segment scanner and its glyph decoder.
//   GLYPH_*      4-bit codes for the named glyphs; GLYPH_BLANK lights nothing.
//   scan_state_t scan sequencer states: OFF (display idle), GUARD_S (all digits
//                dark at the start of a slot), SHOW (current digit lit).
package seg7_pkg;

  localparam logic [3:0] GLYPH_R     = 4'd0;
  localparam logic [3:0] GLYPH_P     = 4'd1;
  localparam logic [3:0] GLYPH_S     = 4'd2;
  localparam logic [3:0] GLYPH_BLANK = 4'd15;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    GUARD_S = 2'd1,
    SHOW    = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: combinational decoder from a 4-bit glyph code to a 7-bit segment
// pattern (active-high, bit 6 first as written in the table below).
//   i_code    : glyph code
//   o_pattern : segment pattern; codes 6..15 give all segments off
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_pattern
);

  always_comb begin
    o_pattern = 7'b0000000;
    case (i_code)
      GLYPH_R: o_pattern = 7'b1101101;
      GLYPH_P: o_pattern = 7'b0110011;
      GLYPH_S: o_pattern = 7'b1110011;
      4'd3:    o_pattern = 7'b1001111;
      4'd4:    o_pattern = 7'b1000000;
      4'd5:    o_pattern = 7'b0111111;
      default: o_pattern = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed seven-segment display driver.
// Each digit owns a slot of SCAN_DIV cycles: GUARD dark cycles to avoid ghosting,
// then the digit is lit. New codes are staged in a pending register and only
// committed at a frame boundary so a frame never shows a mix of old and new codes.
//   Clock, Resetn : clock and asynchronous active-low reset
//   enable        : 0 blanks the display and parks the scan at digit 0
//   codes         : 4-bit glyph code per digit, digit 0 in bits [3:0]
//   load_req      : stage codes into the pending register
//   load_ack      : one-cycle pulse when pending codes reach the display register
//   blink_en      : per-digit blink select
//   seg, an       : registered segment pattern and one-hot digit select,
//                   inverted when ACTIVE_LOW=1
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 500,
  parameter int BLINK_DIV  = 12500000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] codes,
  input  logic                    load_req,
  output logic                    load_ack,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = $clog2(BLINK_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_DIV - 1);

  scan_state_t             r_state;
  scan_state_t             w_stateNext;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [BLK_W-1:0]        r_blinkCnt;
  logic                    r_blinkPhase;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic                    r_pendValid;
  logic                    r_ack;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_slotEnd;
  logic                    w_frameStart;
  logic [4*NUM_DIGITS-1:0] w_pendNext;
  logic                    w_pendValidNext;
  logic                    w_commit;
  logic [3:0]              w_curCode;
  logic [6:0]              w_glyph;

  assign w_curCode = r_disp[{r_idx, 2'b00} +: 4];

  seg7_glyph u_glyph (
    .i_code    (w_curCode),
    .o_pattern (w_glyph)
  );

  // Next-state logic. A frame starts either on leaving OFF or when the last
  // digit's slot ends and the index wraps back to 0.
  always_comb begin
    w_stateNext  = r_state;
    w_slotEnd    = 1'b0;
    w_frameStart = 1'b0;
    if (!enable) begin
      w_stateNext = OFF;
    end else begin
      case (r_state)
        OFF: begin
          w_stateNext  = GUARD_S;
          w_frameStart = 1'b1;
        end
        GUARD_S: begin
          if (r_cnt == GUARD_LAST) w_stateNext = SHOW;
        end
        SHOW: begin
          if (r_cnt == CNT_LAST) begin
            w_stateNext  = GUARD_S;
            w_slotEnd    = 1'b1;
            w_frameStart = (r_idx == IDX_LAST);
          end
        end
        default: w_stateNext = OFF;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= OFF;
    else         r_state <= w_stateNext;
  end

  // Slot counter runs across the whole slot (guard plus lit part); both it and
  // the digit index are held at 0 while the display is off.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!enable || r_state == OFF) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slotEnd) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Blink phase free-runs from reset, independent of enable.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (r_blinkCnt == BLK_LAST) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= ~r_blinkPhase;
    end else begin
      r_blinkCnt <= r_blinkCnt + 1'b1;
    end
  end

  // A request arriving on the commit cycle itself is merged in, so it is
  // committed at once instead of waiting a whole frame.
  assign w_pendNext      = load_req ? codes : r_pend;
  assign w_pendValidNext = load_req | r_pendValid;
  assign w_commit        = w_pendValidNext & (~enable | w_frameStart);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_pend      <= {NUM_DIGITS{GLYPH_BLANK}};
      r_pendValid <= 1'b0;
      r_disp      <= {NUM_DIGITS{GLYPH_BLANK}};
      r_ack       <= 1'b0;
    end else begin
      r_pend      <= w_pendNext;
      r_pendValid <= w_pendValidNext & ~w_commit;
      r_ack       <= w_commit;
      if (w_commit) r_disp <= w_pendNext;
    end
  end

  // Output registers. enable is folded in so a falling enable darkens the
  // pins on the very next cycle rather than one cycle after OFF is reached.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_seg <= '0;
      r_an  <= '0;
    end else begin
      r_seg <= '0;
      r_an  <= '0;
      if (enable && r_state == SHOW) begin
        r_an  <= NUM_DIGITS'(1) << r_idx;
        r_seg <= (r_blinkPhase && blink_en[r_idx]) ? 7'b0000000 : w_glyph;
      end
    end
  end

  assign load_ack = r_ack;
  assign seg      = ACTIVE_LOW ? ~r_seg : r_seg;
  assign an       = ACTIVE_LOW ? ~r_an : r_an;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized self-checking bench for seg7_scan with a small
// scan (4 digits, 8-cycle slots, 2 guard cycles, 64-cycle blink, active-low).
// The reference model tracks elapsed cycles since enable, elapsed cycles since
// reset, and the pending/displayed codes, and derives the pins arithmetically.
module tb_seg7_scan;

  localparam int N  = 4;
  localparam int SD = 8;
  localparam int G  = 2;
  localparam int BD = 64;

  logic          Clock;
  logic          Resetn;
  logic          enable;
  logic [15:0]   codes;
  logic          load_req;
  logic          load_ack;
  logic [3:0]    blink_en;
  logic [6:0]    seg;
  logic [3:0]    an;

  int passCount;
  int checkCount;

  // Reference model state
  bit          mRun;
  int          mElapsed;
  int          mEdges;
  bit          mPendValid;
  logic [15:0] mPend;
  logic [3:0]  mDisp [N];

  seg7_scan #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (SD),
    .GUARD      (G),
    .BLINK_DIV  (BD),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .enable   (enable),
    .codes    (codes),
    .load_req (load_req),
    .load_ack (load_ack),
    .blink_en (blink_en),
    .seg      (seg),
    .an       (an)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [6:0] glyphOf(input logic [3:0] c);
    case (c)
      4'd0:    return 7'b1101101;
      4'd1:    return 7'b0110011;
      4'd2:    return 7'b1110011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1000000;
      4'd5:    return 7'b0111111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic resetModel();
    mRun       = 1'b0;
    mElapsed   = 0;
    mEdges     = 0;
    mPendValid = 1'b0;
    mPend      = 16'hFFFF;
    for (int i = 0; i < N; i++) mDisp[i] = 4'hF;
  endtask

  // Assert reset mid-cycle, check the pins go dark without a clock edge,
  // then release it just after a rising edge.
  task automatic applyReset();
    Resetn = 1'b0;
    #1;
    checkOutput("rst_seg", {9'b0, seg}, 16'h007F);
    checkOutput("rst_an", {12'b0, an}, 16'h000F);
    checkOutput("rst_ack", {15'b0, load_ack}, 16'h0000);
    resetModel();
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;
  endtask

  // One clock: predict the pins from the model as it stood before the edge,
  // advance the model with the inputs seen at the edge, then compare.
  task automatic applyStimulus();
    logic [6:0] expSeg;
    logic [3:0] expAn;
    logic       expAck;
    bit         frameStart;
    int         d;
    @(posedge Clock);
    expSeg = 7'b0;
    expAn  = 4'b0;
    if (enable && mRun && (mElapsed % SD) >= G) begin
      d     = (mElapsed / SD) % N;
      expAn = 4'(1 << d);
      if (!(((mEdges / BD) % 2) == 1 && blink_en[d])) expSeg = glyphOf(mDisp[d]);
    end
    frameStart = 1'b0;
    if (enable) begin
      if (!mRun) begin
        mRun       = 1'b1;
        mElapsed   = 0;
        frameStart = 1'b1;
      end else begin
        mElapsed++;
        frameStart = ((mElapsed % (N * SD)) == 0);
      end
    end else begin
      mRun = 1'b0;
    end
    mEdges++;
    if (load_req) begin
      mPend      = codes;
      mPendValid = 1'b1;
    end
    expAck = 1'b0;
    if (mPendValid && (!enable || frameStart)) begin
      for (int i = 0; i < N; i++) mDisp[i] = mPend[4*i +: 4];
      mPendValid = 1'b0;
      expAck     = 1'b1;
    end
    #1;
    checkOutput("an", {12'b0, an}, {12'b0, ~expAn});
    checkOutput("seg", {9'b0, seg}, {9'b0, ~expSeg});
    checkOutput("load_ack", {15'b0, load_ack}, {15'b0, expAck});
  endtask

  initial begin
    bit found;
    passCount  = 0;
    checkCount = 0;
    Resetn     = 1'b1;
    enable     = 1'b0;
    codes      = 16'h0000;
    load_req   = 1'b0;
    blink_en   = 4'b0000;
    resetModel();
    #3;
    applyReset();

    // Plain scan of blank digits after reset
    enable = 1'b1;
    repeat (40) applyStimulus();

    // Load while disabled commits at once, then scan the new codes
    enable = 1'b0;
    repeat (2) applyStimulus();
    codes    = 16'h0210;
    load_req = 1'b1;
    applyStimulus();
    load_req = 1'b0;
    applyStimulus();
    enable = 1'b1;
    repeat (40) applyStimulus();

    // Two requests mid-frame: last one wins, single ack at frame start
    codes    = 16'h3333;
    load_req = 1'b1;
    applyStimulus();
    codes = 16'h4444;
    applyStimulus();
    load_req = 1'b0;
    repeat (40) applyStimulus();

    // Blink on digit 1 across several blink windows
    blink_en = 4'b0010;
    repeat (200) applyStimulus();
    blink_en = 4'b0000;

    // Drop enable while digit 2 is lit, then re-enable
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (mRun && ((mElapsed / SD) % N) == 2 && (mElapsed % SD) >= G) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("reach_digit2", {15'b0, found}, 16'h0001);
    enable = 1'b0;
    repeat (2) applyStimulus();
    enable = 1'b1;
    repeat (20) applyStimulus();

    // Random traffic
    repeat (1500) begin
      if (($urandom % 50) == 0) enable = ~enable;
      load_req = (($urandom % 8) == 0);
      codes    = 16'($urandom);
      blink_en = 4'($urandom);
      applyStimulus();
    end

    // Reset with a request still pending
    enable   = 1'b1;
    blink_en = 4'b0000;
    repeat (3) applyStimulus();
    codes    = 16'h5555;
    load_req = 1'b1;
    applyStimulus();
    load_req = 1'b0;
    #2;
    applyReset();
    repeat (40) applyStimulus();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
